// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronize, glitch-filter, deframe 11-bit frames, buffer bytes in a show-ahead FIFO.
// Optional odd-parity enforcement in the stop state with macro PS2_PARITY_CHECK_EN.
module ps2_kbd_rx #(
   parameter int CLK_HZ     = 25000000,
   parameter int TIMEOUT_US = 200,
   parameter int FILTER_LEN = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2clk,
   input  logic       ps2dat,
   input  logic       rd,
   input  logic       clr_ovf,
   output logic [7:0] data,
   output logic       valid,
   output logic       overflow,
   output logic       frame_err,
   output logic       busy
);
   localparam int TO    = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int TOW   = $clog2(TO + 1);
   localparam int FW    = $clog2(FILTER_LEN + 1);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic              filt_q, filt_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic              fall;
   state_t            state_q, state_d;
   logic [2:0]        bcnt_q, bcnt_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              err_q, err_d;
   logic [TOW-1:0]    to_q, to_d;
   logic              wr, par_ok;
   logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic              ovf_q, ovf_d;
   logic              empty, full, pop, push;
   logic [7:0]        mem_q [DEPTH];

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shreg_q, par_q};
`else
   assign par_ok = 1'b1;
`endif

   // Level flips only after FILTER_LEN consecutive samples disagreeing with it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else                                fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign fall = filt_q & ~filt_d;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      err_d   = 1'b0;
      wr      = 1'b0;
      if (state_q == IDLE || fall) to_d = TOW'(TO);
      else if (to_q != '0)         to_d = to_q - 1'b1;
      else                         to_d = to_q;
      if (fall) begin
         unique case (state_q)
            IDLE: if (!dat_s2_q) begin
               state_d = DATA;
               bcnt_d  = '0;
            end
            DATA: begin
               shreg_d = {dat_s2_q, shreg_q[7:1]};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_s2_q && par_ok) wr    = 1'b1;
               else                    err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && to_q == '0) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end
   end

   // Full is MSB-differs/low-bits-equal; a same-cycle pop frees the slot being written.
   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
               (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
      pop    = rd && !empty;
      push   = wr && (!full || pop);
      rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      ovf_d  = ovf_q;
      if (clr_ovf)            ovf_d = 1'b0;
      if (wr && full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= IDLE;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= TOW'(TO);
      end else begin
         clk_s1_q <= ps2clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2dat;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         err_q    <= err_d;
         to_q     <= to_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= shreg_q;
      end
   end

   assign data      = mem_q[rptr_q[FIFO_AW-1:0]];
   assign valid     = !empty;
   assign overflow  = ovf_q;
   assign frame_err = err_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: queue model of the FIFO, pops checked by an independent monitor.
module tb_ps2_kbd_rx;
   localparam int DEPTH = 8;
   localparam int H     = 40;   // PS/2 half period in system clocks
   localparam int TO    = 500;  // 25 MHz * 20 us

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic       clk = 0, reset_n = 0, ps2clk = 1, ps2dat = 1, rd = 0, clr_ovf = 0;
   logic [7:0] data;
   logic       valid, overflow, frame_err, busy;

   ps2_kbd_rx #(.CLK_HZ(25000000), .TIMEOUT_US(20), .FILTER_LEN(8), .FIFO_AW(3)) dut (
      .clk(clk), .reset_n(reset_n), .ps2clk(ps2clk), .ps2dat(ps2dat), .rd(rd),
      .clr_ovf(clr_ovf), .data(data), .valid(valid), .overflow(overflow),
      .frame_err(frame_err), .busy(busy));

   always #20 clk = ~clk;

   int         n_cmp = 0, n_mis = 0;
   logic [7:0] mq[$];
   bit         m_ovf = 0;
   int         err_exp = 0, err_seen = 0;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(logic [10:0] fr, int nb);
      for (int i = 0; i < nb; i++) begin
         ps2dat = fr[i];
         cyc(H/2);
         ps2clk = 0;
         cyc(H);
         ps2clk = 1;
         cyc(H/2);
      end
      ps2dat = 1;
   endtask

   function automatic logic [10:0] mk_frame(logic [7:0] b, bit bad_par, bit stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {stop, par, b, 1'b0};
   endfunction

   // Reference: a good frame enters the queue unless 8 bytes are held; a bad one is one error pulse.
   task automatic model_frame(logic [7:0] b, bit bad_par, bit stop);
      if (stop && !(PCHK && bad_par)) begin
         if (mq.size() == DEPTH) m_ovf = 1;
         else                    mq.push_back(b);
      end else err_exp++;
   endtask

   task automatic send_frame(logic [7:0] b, bit bad_par, bit stop);
      send_bits(mk_frame(b, bad_par, stop), 11);
      model_frame(b, bad_par, stop);
   endtask

   task automatic do_rd();
      @(posedge clk); #1 rd = 1;
      @(posedge clk); #1 rd = 0;
   endtask

   task automatic checkpoint(string nm);
      chk({nm, ".valid"}, valid, mq.size() != 0);
      if (mq.size() != 0) chk({nm, ".data"}, data, mq[0]);
      chk({nm, ".overflow"}, overflow, m_ovf);
      chk({nm, ".frame_err_count"}, err_seen, err_exp);
      chk({nm, ".busy"}, busy, 0);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_err) err_seen++;
         if (rd && valid) begin
            if (mq.size() == 0) begin
               n_cmp++; n_mis++;
               $display("FAIL pop_extra: got %0h expected no byte", data);
            end else chk("pop_data", data, mq.pop_front());
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [10:0] fr;
      reset_n = 0;
      cyc(3);
      chk("rst.data", data, 0);
      chk("rst.valid", valid, 0);
      chk("rst.overflow", overflow, 0);
      chk("rst.frame_err", frame_err, 0);
      chk("rst.busy", busy, 0);
      reset_n = 1;
      cyc(5);

      // 0x1C with latency measured from the stop-bit clock edge
      send_bits(mk_frame(8'h1C, 0, 1), 10);
      ps2dat = 1;
      cyc(H/2);
      ps2clk = 0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc(1);
         if (valid) begin n = i; break; end
      end
      chk("latency_window", (n >= 8 && n <= 14), 1);
      cyc(H - n);
      ps2clk = 1;
      cyc(H/2);
      model_frame(8'h1C, 0, 1);
      checkpoint("f1c");
      do_rd();
      cyc(1);
      checkpoint("f1c_rd");
      do_rd();   // rd while empty is ignored
      checkpoint("rd_empty");

      send_frame(8'hF0, 0, 1);
      send_frame(8'h1C, 0, 1);
      checkpoint("b2b");
      do_rd();
      checkpoint("b2b_rd1");
      do_rd();
      checkpoint("b2b_rd2");

      send_frame(8'h1C, 1, 1);
      checkpoint("parity");
      while (mq.size() != 0) do_rd();
      checkpoint("parity_drain");

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1);
      checkpoint("ovf");
      for (int i = 0; i < 8; i++) do_rd();
      checkpoint("ovf_drained");
      clr_ovf = 1; cyc(1); clr_ovf = 0;
      m_ovf = 0;
      cyc(1);
      checkpoint("clr_ovf");

      send_bits(mk_frame(8'h55, 0, 1), 5);
      cyc(2 * TO);
      err_exp++;
      send_frame(8'h29, 0, 1);
      checkpoint("timeout");
      do_rd();
      checkpoint("timeout_rd");

      send_frame(8'h3A, 0, 0);
      checkpoint("bad_stop");

      for (int i = 0; i < 6; i++) begin
         cyc(3);
         #($urandom_range(18));
         ps2clk = 0;
         #20 ps2clk = 1;
         cyc(2);
         chk("glitch.busy", busy, 0);
      end
      checkpoint("glitch");

      for (int i = 0; i < 10; i++) begin
         send_frame(8'($urandom), $urandom_range(3) == 0, $urandom_range(7) != 0);
         if ($urandom_range(1) == 1) do_rd();
      end
      checkpoint("rand");
      for (int i = 0; i < DEPTH + 1; i++) do_rd();
      clr_ovf = 1; cyc(1); clr_ovf = 0;
      m_ovf = 0;
      cyc(1);
      checkpoint("rand_drain");

      send_frame(8'h11, 0, 1);
      send_bits(mk_frame(8'h77, 0, 1), 5);
      reset_n = 0;
      cyc(3);
      mq.delete();
      m_ovf = 0;
      chk("midrst.data", data, 0);
      chk("midrst.valid", valid, 0);
      chk("midrst.overflow", overflow, 0);
      chk("midrst.frame_err", frame_err, 0);
      chk("midrst.busy", busy, 0);
      reset_n = 1;
      cyc(5);
      send_frame(8'h5A, 0, 1);
      checkpoint("after_rst");
      do_rd();
      checkpoint("after_rst_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
